hazard_pipe_ctrl: RTL and testbench
===================================

Name: hazard_pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Drives the enable and clear inputs of the PC, F/D, D/E and E/M pipeline registers.
- Detects load-use and branch-compare data hazards.
- Tracks the multi-cycle mult/div unit with a busy counter.
- Sequences ERET, which waits for in-flight CP0 writes, and M-stage exception flushes.

Parameters:
MULT_LAT, 5, busy cycles after a mult/multu issue in E
DIV_LAT, 10, busy cycles after a div/divu issue in E
CNT_W, 4, mult/div counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
rsD  in  5  D-stage rs field
rtD  in  5  D-stage rt field
useRsD  in  1  D instruction reads rs in D or E
useRtD  in  1  D instruction reads rt in D or E
branchD  in  1  D instruction is a branch/jr that compares in D
mdUseD  in  1  D instruction reads HI/LO or is mult/div
eretD  in  1  D instruction is ERET
regWriteE  in  1  E instruction writes GPR
memReadE  in  1  E instruction is a load
writeRegE  in  5  E destination register
regWriteM  in  1  M instruction writes GPR
memReadM  in  1  M instruction is a load
writeRegM  in  5  M destination register
mdStartE  in  1  mult/div issuing in E this cycle
mdIsDivE  in  1  the issuing op is a divide
cp0WriteE  in  1  mtc0 in E
cp0WriteM  in  1  mtc0 in M
excM  in  1  exception/interrupt taken at M
enPC  out  1  PC register enable
enFD  out  1  F/D register enable
clrDE  out  1  D/E clear (bubble insert)
clrEM  out  1  E/M clear
eretSelF  out  1  PC-next mux selects EPC
excSelF  out  1  PC-next mux selects handler vector
mdBusy  out  1  mult/div counter nonzero
mdAbort  out  1  abort the mult/div unit

Behaviour:
- Reset: state=RUN, mdCnt=0. Outputs after reset: enPC=1, enFD=1, all clr/sel/abort=0, mdBusy=0.
- Register 0 never matches in any hazard check.
- loadUse = memReadE & regWriteE & writeRegE≠0 & ((useRsD & rsD==writeRegE) | (useRtD & rtD==writeRegE)).
- brHaz = branchD & ((regWriteE & writeRegE matches rs/rt) | (memReadM & writeRegM matches rs/rt)).
- mdStall = mdUseD & (mdBusy | mdStartE).
- mdCnt (sequential):
  - Loads DIV_LAT if mdIsDivE, else MULT_LAT, when mdStartE.
  - Otherwise decrements while nonzero.
  - Clears on excM or reset.
  - mdBusy = (mdCnt≠0).
- FSM:
  - RUN:
    - eretD & no other stall & (cp0WriteE|cp0WriteM) -> ERET_HOLD.
    - eretD & no other stall & no CP0 write pending -> ERET_GO.
  - ERET_HOLD: stall D. Goes to ERET_GO the first cycle both cp0WriteE and cp0WriteM are 0.
  - ERET_GO (exactly 1 cycle): eretSelF=1, enPC=1, enFD=1. The F/D register self-clears on eretD&enable. Then -> RUN.
- stallD = loadUse | brHaz | mdStall | (state==ERET_HOLD) | (state==RUN & eretD).
  - During stallD: enPC=0, enFD=0, clrDE=1.
- Priority, highest first:
  1. excM: enPC=1, enFD=1, clrDE=1, clrEM=1, excSelF=1, mdAbort=1. FSM -> RUN, overriding any ERET state.
  2. ERET_GO.
  3. stallD.
  4. Normal: enPC=enFD=1, clears=0.
- Simultaneous mdStartE and mdUseD: stall. Counter loads on that edge.
- mdUseD while mdCnt==1: still stalls this cycle; issues next cycle.
- reset mid-ERET_HOLD: returns to RUN; no eretSelF pulse.
- All outputs are combinational from state, mdCnt and inputs. State and mdCnt are the only registers.

Optional Feature:
HAZARD_PERF_CNT_EN. When defined, adds two outputs:
- stallCycles[31:0]: counts cycles with stallD=1 and excM=0.
- flushCount[15:0]: counts excM pulses.

Both reset to 0 and wrap on overflow. When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- lw $2 in E (writeRegE=2, memReadE=1), D reads rs=2 -> exactly 1 cycle of enPC=0, enFD=0, clrDE=1; normal next cycle.
- div in E (mdStartE=1, mdIsDivE=1), mfhi in D -> stall for 11 cycles (issue cycle + 10); mdBusy high for 10 cycles; mfhi advances when mdCnt==0.
- eretD with cp0WriteE=1, then cp0WriteM=1, then both 0 -> ERET_HOLD 2 cycles, then one ERET_GO cycle with eretSelF=1, then RUN.
- excM asserted while in ERET_HOLD with mdCnt=6 -> same cycle: clrDE=clrEM=excSelF=mdAbort=1; next cycle state=RUN, mdCnt=0, eretSelF never pulses.
- beq in D with rs=5 and lw $5 in M -> 1-cycle stall; with writeRegE=0 and regWriteE=1 -> no stall.
- reset asserted for 1 cycle mid-stall -> next cycle enPC=1, enFD=1, all clears 0, mdBusy=0.

Source files
------------

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: stall/flush sequencer for the 5-stage MIPS32 pipeline.
// Generates PC/F-D enables and D-E/E-M clears from load-use, branch-compare
// and mult/div hazards. Sequences ERET behind in-flight CP0 writes, and
// handles M-stage exception flushes.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stallCycles/flushCount.
module hazard_pipe_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       useRsD,
  input  logic       useRtD,
  input  logic       branchD,
  input  logic       mdUseD,
  input  logic       eretD,
  input  logic       regWriteE,
  input  logic       memReadE,
  input  logic [4:0] writeRegE,
  input  logic       regWriteM,
  input  logic       memReadM,
  input  logic [4:0] writeRegM,
  input  logic       mdStartE,
  input  logic       mdIsDivE,
  input  logic       cp0WriteE,
  input  logic       cp0WriteM,
  input  logic       excM,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stallCycles,
  output logic [15:0] flushCount,
`endif
  output logic       enPC,
  output logic       enFD,
  output logic       clrDE,
  output logic       clrEM,
  output logic       eretSelF,
  output logic       excSelF,
  output logic       mdBusy,
  output logic       mdAbort
);

  typedef enum logic [1:0] {RUN, ERET_HOLD, ERET_GO} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  // Hazard detection; $0 is never a real producer, so it never matches.
  logic e_nz, m_nz;
  logic e_rs, e_rt, m_rs, m_rt;
  logic load_use, br_haz, md_stall, other_stall, stall_d;

  assign e_nz = (writeRegE != 5'd0);
  assign m_nz = (writeRegM != 5'd0);
  assign e_rs = e_nz & (rsD == writeRegE);
  assign e_rt = e_nz & (rtD == writeRegE);
  assign m_rs = m_nz & (rsD == writeRegM);
  assign m_rt = m_nz & (rtD == writeRegM);

  assign load_use    = memReadE & regWriteE & ((useRsD & e_rs) | (useRtD & e_rt));
  assign br_haz      = branchD & ((regWriteE & (e_rs | e_rt)) |
                                  (memReadM  & (m_rs | m_rt)));
  assign mdBusy      = (md_cnt_q != '0);
  assign md_stall    = mdUseD & (mdBusy | mdStartE);
  assign other_stall = load_use | br_haz | md_stall;
  assign stall_d     = other_stall | (state_q == ERET_HOLD) |
                       ((state_q == RUN) & eretD);

  // ERET sequencing; an exception always drops back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (eretD & ~other_stall)
                   state_d = (cp0WriteE | cp0WriteM) ? ERET_HOLD : ERET_GO;
      ERET_HOLD: if (~cp0WriteE & ~cp0WriteM) state_d = ERET_GO;
      ERET_GO:   state_d = RUN;
      default:   state_d = RUN;
    endcase
    if (excM) state_d = RUN;
  end

  // Mult/div busy counter: load on issue, count down, flush on exception.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (excM)
      md_cnt_d = '0;
    else if (mdStartE)
      md_cnt_d = mdIsDivE ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Pipeline control outputs, exception > ERET_GO > stall > normal.
  always_comb begin
    enPC     = 1'b1;
    enFD     = 1'b1;
    clrDE    = 1'b0;
    clrEM    = 1'b0;
    eretSelF = 1'b0;
    excSelF  = 1'b0;
    mdAbort  = 1'b0;
    if (excM) begin
      clrDE   = 1'b1;
      clrEM   = 1'b1;
      excSelF = 1'b1;
      mdAbort = 1'b1;
    end else if (state_q == ERET_GO) begin
      eretSelF = 1'b1;
    end else if (stall_d) begin
      enPC  = 1'b0;
      enFD  = 1'b0;
      clrDE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Event counters; both wrap naturally.
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, (stall_d & ~excM)};
    flush_count_d  = flush_count_q + {15'd0, excM};
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Scoreboard bench for hazard_pipe_ctrl: the driver pushes the hand-computed
// output vector for each cycle; a negedge monitor pops and compares.
// Vector order: {enPC, enFD, clrDE, clrEM, eretSelF, excSelF, mdBusy, mdAbort}
module tb_hazard_pipe_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsD, rtD, writeRegE, writeRegM;
  logic useRsD, useRtD, branchD, mdUseD, eretD;
  logic regWriteE, memReadE, regWriteM, memReadM;
  logic mdStartE, mdIsDivE, cp0WriteE, cp0WriteM, excM;
  logic enPC, enFD, clrDE, clrEM, eretSelF, excSelF, mdBusy, mdAbort;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles;
  logic [15:0] flushCount;
`endif

  always #5 clk = ~clk;

  hazard_pipe_ctrl dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .useRsD(useRsD),
    .useRtD(useRtD), .branchD(branchD), .mdUseD(mdUseD), .eretD(eretD),
    .regWriteE(regWriteE), .memReadE(memReadE), .writeRegE(writeRegE),
    .regWriteM(regWriteM), .memReadM(memReadM), .writeRegM(writeRegM),
    .mdStartE(mdStartE), .mdIsDivE(mdIsDivE), .cp0WriteE(cp0WriteE),
    .cp0WriteM(cp0WriteM), .excM(excM),
`ifdef HAZARD_PERF_CNT_EN
    .stallCycles(stallCycles), .flushCount(flushCount),
`endif
    .enPC(enPC), .enFD(enFD), .clrDE(clrDE), .clrEM(clrEM),
    .eretSelF(eretSelF), .excSelF(excSelF), .mdBusy(mdBusy), .mdAbort(mdAbort)
  );

  localparam logic [7:0] NORM  = 8'hC0;  // enPC, enFD
  localparam logic [7:0] STL   = 8'h20;  // stall, counter idle
  localparam logic [7:0] STLB  = 8'h22;  // stall, mdBusy
  localparam logic [7:0] NORMB = 8'hC2;  // running, mdBusy
  localparam logic [7:0] EGO   = 8'hC8;  // eretSelF pulse
  localparam logic [7:0] EXC   = 8'hF5;  // exception flush, counter idle
  localparam logic [7:0] EXCB  = 8'hF7;  // exception flush, counter was busy

  typedef struct {
    logic [7:0] exp;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] act;
  assign act = {enPC, enFD, clrDE, clrEM, eretSelF, excSelF, mdBusy, mdAbort};

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s got %b exp %b", e.nm, act, e.exp);
      end
    end
  end

  task automatic idle();
    rsD = 5'd0; rtD = 5'd0; useRsD = 1'b0; useRtD = 1'b0; branchD = 1'b0;
    mdUseD = 1'b0; eretD = 1'b0; regWriteE = 1'b0; memReadE = 1'b0;
    writeRegE = 5'd0; regWriteM = 1'b0; memReadM = 1'b0; writeRegM = 5'd0;
    mdStartE = 1'b0; mdIsDivE = 1'b0; cp0WriteE = 1'b0; cp0WriteM = 1'b0;
    excM = 1'b0;
  endtask

  task automatic step(input logic [7:0] e, input string nm);
    exp_t x;
    x.exp = e;
    x.nm  = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    step(NORM, "reset_state");

    // load-use on rs, then bubble has moved on
    regWriteE = 1; memReadE = 1; writeRegE = 5'd2; useRsD = 1; rsD = 5'd2;
    step(STL, "loaduse_rs");
    idle(); useRsD = 1; rsD = 5'd2;
    step(NORM, "loaduse_after");
    // load-use on rt
    idle(); regWriteE = 1; memReadE = 1; writeRegE = 5'd9; useRtD = 1; rtD = 5'd9;
    step(STL, "loaduse_rt");
    // load to $0 never stalls
    idle(); regWriteE = 1; memReadE = 1; useRsD = 1; useRtD = 1;
    step(NORM, "loaduse_r0");
    // field matches but not used
    idle(); regWriteE = 1; memReadE = 1; writeRegE = 5'd4; rsD = 5'd4;
    step(NORM, "loaduse_unused");

    // div issue with mfhi waiting: 1 + 10 stall cycles, then advance
    idle(); mdStartE = 1; mdIsDivE = 1; mdUseD = 1;
    step(STL, "div_issue");
    idle(); mdUseD = 1;
    for (int i = 0; i < 10; i++) step(STLB, $sformatf("div_busy%0d", i));
    step(NORM, "div_done");

    // mult issue, nothing waiting: busy 5 cycles, no stall
    idle(); mdStartE = 1;
    step(NORM, "mult_issue");
    idle();
    for (int i = 0; i < 5; i++) step(NORMB, $sformatf("mult_busy%0d", i));
    step(NORM, "mult_done");

    // ERET behind CP0 writes in E then M
    idle(); eretD = 1; cp0WriteE = 1;
    step(STL, "eret_run");
    cp0WriteE = 0; cp0WriteM = 1;
    step(STL, "eret_hold1");
    cp0WriteM = 0;
    step(STL, "eret_hold2");
    step(EGO, "eret_go");
    idle();
    step(NORM, "eret_after");

    // ERET with nothing pending
    eretD = 1;
    step(STL, "eret_fast_run");
    step(EGO, "eret_fast_go");
    idle();
    step(NORM, "eret_fast_after");

    // exception while in ERET_HOLD with mdCnt=6
    eretD = 1; cp0WriteE = 1; mdStartE = 1; mdIsDivE = 1;
    step(STL, "exc_setup");
    mdStartE = 0; mdIsDivE = 0;
    for (int i = 0; i < 4; i++) step(STLB, $sformatf("exc_hold%0d", i));
    excM = 1;
    step(EXCB, "exc_flush");
    idle();
    step(NORM, "exc_after");
    excM = 1;
    step(EXC, "exc_idle");

    // branch vs load in M, then clears
    idle(); branchD = 1; rsD = 5'd5; memReadM = 1; regWriteM = 1; writeRegM = 5'd5;
    step(STL, "br_load_m");
    idle(); branchD = 1; rsD = 5'd5;
    step(NORM, "br_after");
    // branch vs ALU producer in E on rt
    idle(); branchD = 1; rtD = 5'd7; regWriteE = 1; writeRegE = 5'd7;
    step(STL, "br_alu_e");
    // producer writes $0
    idle(); branchD = 1; regWriteE = 1;
    step(NORM, "br_r0");
    // ALU in M is forwardable, no stall
    idle(); branchD = 1; rsD = 5'd3; regWriteM = 1; writeRegM = 5'd3;
    step(NORM, "br_alu_m");

    // reset during a mult/div stall
    idle(); mdStartE = 1; mdIsDivE = 1; mdUseD = 1;
    step(STL, "rst_issue");
    mdStartE = 0; mdIsDivE = 0; reset = 1;
    step(STLB, "rst_cycle");
    reset = 0;
    step(NORM, "rst_after");
    idle();

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d need=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
